// File: rtl/lc2k_writeback_if.sv
// rtl/lc2k_writeback_if.sv - register-write request handshake into the writeback queue
interface lc2k_writeback_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 3
) ();
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_reg;
    logic [DATA_W-1:0] wb_val;

    modport master (
        output wb_valid,
        output wb_reg,
        output wb_val,
        input  wb_ready
    );

    modport slave (
        input  wb_valid,
        input  wb_reg,
        input  wb_val,
        output wb_ready
    );
endinterface

// File: rtl/lc2k_writeback.sv
// rtl/lc2k_writeback.sv - in-order register-file write queue with forwarding and pending scoreboard
module lc2k_writeback #(
    parameter int DEPTH   = 4,
    parameter int DATA_W  = 32,
    parameter int REG_W   = 3,
    parameter int DROP_R0 = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    lc2k_writeback_if.slave         wb,
    input  logic                    rf_hold,
    output logic                    rf_write_enable,
    output logic [REG_W-1:0]        rf_write_reg,
    output logic [DATA_W-1:0]       rf_write_val,
    input  logic [REG_W-1:0]        fwd_regA,
    input  logic [REG_W-1:0]        fwd_regB,
    output logic                    fwd_hitA,
    output logic [DATA_W-1:0]       fwd_valA,
    output logic                    fwd_hitB,
    output logic [DATA_W-1:0]       fwd_valB,
    output logic [(1<<REG_W)-1:0]   pending_mask,
    output logic                    empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_W-1:0]  q_reg [DEPTH];
    logic [DATA_W-1:0] q_val [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  idx;

    logic transfer;
    logic drop;
    logic push;
    logic pop;

    assign wb.wb_ready = !reset && (count < CNT_W'(DEPTH));
    assign transfer    = wb.wb_valid && wb.wb_ready;
    assign drop        = (DROP_R0 != 0) && (wb.wb_reg == '0);
    assign push        = transfer && !drop;
    // Pop uses the start-of-cycle count, so an entry pushed on this edge cannot bypass to the output.
    assign pop         = (count != '0) && !rf_hold;

    always_ff @(posedge clk) begin
        if (push) begin
            q_reg[tail] <= wb.wb_reg;
            q_val[tail] <= wb.wb_val;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            rf_write_enable <= 1'b0;
            rf_write_reg    <= '0;
            rf_write_val    <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (pop) begin
                rf_write_enable <= 1'b1;
                rf_write_reg    <= q_reg[head];
                rf_write_val    <= q_val[head];
                head            <= head + PTR_W'(1);
            end else begin
                rf_write_enable <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    function automatic logic can_hit(input logic [REG_W-1:0] addr, input logic [REG_W-1:0] r);
        can_hit = (addr == r) && !((DROP_R0 != 0) && (addr == '0));
    endfunction

    // Walk oldest to youngest (output register first, then head..tail-1) so the youngest match overwrites.
    always_comb begin
        pending_mask = '0;
        fwd_hitA     = 1'b0;
        fwd_valA     = '0;
        fwd_hitB     = 1'b0;
        fwd_valB     = '0;
        idx          = '0;
        if (!reset) begin
            if (rf_write_enable) begin
                pending_mask[rf_write_reg] = 1'b1;
                if (can_hit(fwd_regA, rf_write_reg)) begin
                    fwd_hitA = 1'b1;
                    fwd_valA = rf_write_val;
                end
                if (can_hit(fwd_regB, rf_write_reg)) begin
                    fwd_hitB = 1'b1;
                    fwd_valB = rf_write_val;
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) < count) begin
                    idx = head + PTR_W'(i);
                    pending_mask[q_reg[idx]] = 1'b1;
                    if (can_hit(fwd_regA, q_reg[idx])) begin
                        fwd_hitA = 1'b1;
                        fwd_valA = q_val[idx];
                    end
                    if (can_hit(fwd_regB, q_reg[idx])) begin
                        fwd_hitB = 1'b1;
                        fwd_valB = q_val[idx];
                    end
                end
            end
        end
    end

    assign empty = reset || ((count == '0) && !rf_write_enable);
endmodule

// File: tb/tb_lc2k_writeback.sv
// tb/tb_lc2k_writeback.sv - randomized scoreboard bench for lc2k_writeback
module tb_lc2k_writeback;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int REG_W  = 3;

    typedef struct packed {
        logic [REG_W-1:0]  r;
        logic [DATA_W-1:0] v;
    } wr_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              rf_hold;
    logic              rf_write_enable;
    logic [REG_W-1:0]  rf_write_reg;
    logic [DATA_W-1:0] rf_write_val;
    logic [REG_W-1:0]  fwd_regA;
    logic [REG_W-1:0]  fwd_regB;
    logic              fwd_hitA;
    logic [DATA_W-1:0] fwd_valA;
    logic              fwd_hitB;
    logic [DATA_W-1:0] fwd_valB;
    logic [7:0]        pending_mask;
    logic              empty;

    lc2k_writeback_if #(.DATA_W(DATA_W), .REG_W(REG_W)) wb_if ();

    lc2k_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W), .REG_W(REG_W), .DROP_R0(1)) dut (
        .clk             (clk),
        .reset           (reset),
        .wb              (wb_if.slave),
        .rf_hold         (rf_hold),
        .rf_write_enable (rf_write_enable),
        .rf_write_reg    (rf_write_reg),
        .rf_write_val    (rf_write_val),
        .fwd_regA        (fwd_regA),
        .fwd_regB        (fwd_regB),
        .fwd_hitA        (fwd_hitA),
        .fwd_valA        (fwd_valA),
        .fwd_hitB        (fwd_hitB),
        .fwd_valB        (fwd_valB),
        .pending_mask    (pending_mask),
        .empty           (empty)
    );

    always #5 clk = ~clk;

    // Reference state: every accepted non-r0 write stays in pend until its strobe is observed.
    wr_t  pend[$];
    int   occ;
    logic exp_en;
    int   checks;
    int   fails;
    logic [REG_W-1:0]  last_reg;
    logic [DATA_W-1:0] last_val;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W:0] model_fwd(input logic [REG_W-1:0] a);
        model_fwd = '0;
        if (a != 0) begin
            foreach (pend[i]) begin
                if (pend[i].r == a) model_fwd = {1'b1, pend[i].v};
            end
        end
    endfunction

    function automatic logic [7:0] model_mask();
        model_mask = '0;
        foreach (pend[i]) model_mask[pend[i].r] = 1'b1;
    endfunction

    initial begin : monitor
        logic [DATA_W:0] fa;
        logic [DATA_W:0] fb;
        wr_t w;
        last_reg = '0;
        last_val = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                chk("rst_ready", wb_if.wb_ready, 0);
                chk("rst_empty", empty, 1);
                chk("rst_wen", rf_write_enable, 0);
                chk("rst_mask", pending_mask, 0);
                chk("rst_fwdA", {fwd_hitA, fwd_valA}, 0);
                chk("rst_fwdB", {fwd_hitB, fwd_valB}, 0);
                chk("rst_wreg", rf_write_reg, 0);
                chk("rst_wval", rf_write_val, 0);
                last_reg = '0;
                last_val = '0;
            end else begin
                fa = model_fwd(fwd_regA);
                fb = model_fwd(fwd_regB);
                chk("ready", wb_if.wb_ready, occ < DEPTH);
                chk("empty", empty, (occ == 0) && !exp_en);
                chk("wen", rf_write_enable, exp_en);
                chk("mask", pending_mask, model_mask());
                chk("fwdA", {fwd_hitA, fwd_valA}, fa);
                chk("fwdB", {fwd_hitB, fwd_valB}, fb);
                if (rf_write_enable) begin
                    if (pend.size() == 0) begin
                        chk("spurious_write", 1, 0);
                    end else begin
                        w = pend.pop_front();
                        chk("write_reg", rf_write_reg, w.r);
                        chk("write_val", rf_write_val, w.v);
                    end
                    last_reg = rf_write_reg;
                    last_val = rf_write_val;
                end else begin
                    chk("hold_reg", rf_write_reg, last_reg);
                    chk("hold_val", rf_write_val, last_val);
                end
            end
        end
    end

    task automatic step(input bit rst, input bit v, input bit h, input logic [REG_W-1:0] r,
                        input logic [DATA_W-1:0] val, input logic [REG_W-1:0] fa,
                        input logic [REG_W-1:0] fb);
        bit xfer;
        bit pop;
        @(negedge clk);
        #1;
        reset          = rst;
        wb_if.wb_valid = v;
        wb_if.wb_reg   = r;
        wb_if.wb_val   = val;
        rf_hold        = h;
        fwd_regA       = fa;
        fwd_regB       = fb;
        if (rst) begin
            occ    = 0;
            exp_en = 1'b0;
            pend.delete();
        end else begin
            xfer   = v && (occ < DEPTH);
            pop    = (occ > 0) && !h;
            exp_en = pop;
            occ    = occ - int'(pop) + int'(xfer && (r != 0));
            if (xfer && (r != 0)) pend.push_back('{r: r, v: val});
        end
    endtask

    task automatic phase(input int n, input int pv, input int ph, input int prst, input int rmax);
        logic [REG_W-1:0] r;
        logic [REG_W-1:0] fa;
        logic [REG_W-1:0] fb;
        for (int i = 0; i < n; i++) begin
            r  = REG_W'($urandom_range(rmax, 0));
            fa = REG_W'($urandom_range(7, 0));
            fb = REG_W'($urandom_range(7, 0));
            if (pend.size() > 0 && $urandom_range(1, 0) == 1) fa = pend[pend.size()-1].r;
            step($urandom_range(999, 0) < prst, $urandom_range(99, 0) < pv,
                 $urandom_range(99, 0) < ph, r, $urandom, fa, fb);
        end
    endtask

    initial begin : stimulus
        checks = 0;
        fails  = 0;
        occ    = 0;
        exp_en = 1'b0;
        reset  = 1'b1;
        rf_hold = 1'b0;
        wb_if.wb_valid = 1'b0;
        wb_if.wb_reg   = '0;
        wb_if.wb_val   = '0;
        fwd_regA = '0;
        fwd_regB = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        // Two back-to-back writes drain two cycles after the first accept.
        step(0, 1, 0, 3, 32'h11, 3, 5);
        step(0, 1, 0, 5, 32'h22, 3, 5);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 3, 5);
        // Overfill while the port is held, then release.
        for (int i = 0; i < 6; i++) step(0, 1, 1, REG_W'(i + 1), 32'h100 + i, 2, 4);
        for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0, 2, 4);
        // Repeated target: youngest value must forward.
        step(0, 1, 1, 2, 32'hA, 2, 2);
        step(0, 1, 1, 2, 32'hB, 2, 2);
        step(0, 0, 1, 0, 0, 2, 2);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 2, 0);
        // r0 writes are accepted and discarded.
        step(0, 1, 0, 0, 32'hFFFF, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);
        // Full queue, then continuous traffic with no hold.
        for (int i = 0; i < 5; i++) step(0, 1, 1, 7, 32'h700 + i, 7, 1);
        for (int i = 0; i < 20; i++) step(0, 1, 0, REG_W'(i % 7 + 1), 32'h800 + i, 7, REG_W'(i % 8));
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 7, 1);
        // Reset with a strobe in flight and entries queued.
        for (int i = 0; i < 4; i++) step(0, 1, 1, REG_W'(i + 1), 32'h900 + i, 1, 4);
        step(0, 1, 0, 6, 32'h9FF, 1, 6);
        step(1, 0, 0, 0, 0, 1, 6);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 6);

        phase(500, 60, 30, 0, 7);
        phase(500, 90, 10, 5, 2);
        phase(500, 95, 70, 3, 7);
        phase(500, 40, 0, 0, 7);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);

        @(negedge clk);
        #2;
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/lc2k_writeback.md
Name: lc2k_writeback

Overview:
- Writeback-side initiator for the LC2K 8x32 register file.
- Accepts register-write requests from the execute/memory stages over a valid/ready handshake and buffers them in an in-order queue.
- Drains one entry per cycle onto the register file write port (write enable, 3-bit write register, 32-bit write value).
- Gives decode a forwarding lookup on two read addresses, plus a pending-write scoreboard, so data hazards against queued writes are resolved.

Parameters:
- DEPTH, 4: queue entries; power of two, at least 2.
- DATA_W, 32: register value width.
- REG_W, 3: register index width (8 registers).
- DROP_R0, 1: when 1, writes to r0 are handshaken and discarded, and lookups of r0 never hit.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- wb_valid  in  1  producer has a write request.
- wb_ready  out  1  block can accept a request this cycle.
- wb_reg  in  REG_W  destination register.
- wb_val  in  DATA_W  value to write.
- rf_hold  in  1  register file write port owned elsewhere; do not drain.
- rf_write_enable  out  1  register file write strobe (registered).
- rf_write_reg  out  REG_W  register file write index (registered).
- rf_write_val  out  DATA_W  register file write data (registered).
- fwd_regA  in  REG_W  decode lookup address A.
- fwd_regB  in  REG_W  decode lookup address B.
- fwd_hitA  out  1  a pending write targets fwd_regA.
- fwd_valA  out  DATA_W  youngest pending value for fwd_regA; 0 when no hit.
- fwd_hitB  out  1  same as fwd_hitA, for fwd_regB.
- fwd_valB  out  DATA_W  same as fwd_valA, for fwd_regB.
- pending_mask  out  8  bit i set if any pending write targets register i.
- empty  out  1  queue empty and no write strobe in flight.

Behaviour:
- Reset (sync, active-high):
  - Clears head/tail pointers and count.
  - Drives rf_write_enable=0, rf_write_reg=0, rf_write_val=0.
  - While reset is high: wb_ready=0, fwd_hitA/B=0, fwd_valA/B=0, pending_mask=0, empty=1.
  - Reset mid-operation discards all queued entries and any in-flight strobe; no partial write is emitted afterwards.
- Handshake:
  - wb_ready = !reset && (count < DEPTH), derived from the start-of-cycle count.
  - A transfer occurs when wb_valid && wb_ready at a rising edge.
  - A pop in the same cycle does not raise wb_ready when full.
  - wb_reg/wb_val are sampled only on transfer.
- R0 drop: with DROP_R0=1 and wb_reg==0, the transfer completes and nothing is enqueued (count unchanged).
- Enqueue: the entry is written at tail, tail wraps modulo DEPTH, and count increments.
- Drain, evaluated at each edge:
  - If count>0 && !rf_hold: rf_write_enable<=1, rf_write_reg/val<=head entry; head pops and wraps, count decrements.
  - Otherwise rf_write_enable<=0; rf_write_reg/val hold their last values.
  - Exactly one write per cycle maximum.
- Latency:
  - An entry accepted at edge N is poppable no earlier than edge N+1 (no same-edge bypass).
  - Its strobe is therefore visible in the cycle after edge N+1 (2 cycles from accept).
  - Push into an empty queue plus pop of the same entry on the same edge is impossible.
- Simultaneous push and pop: count unchanged; both pointers advance.
- Ordering: strictly FIFO; writes reach the register file in acceptance order, including repeated writes to the same register.
- Forwarding (combinational on fwd_reg*):
  - Candidates are all valid queue entries plus the output register when rf_write_enable=1.
  - Youngest matching entry wins: queue tail-1 down to head, then the output register.
  - With DROP_R0=1, an address of 0 never hits.
- pending_mask: OR of one-hot decodes of every valid queue entry's register, plus rf_write_reg when rf_write_enable=1.
- empty = (count==0) && !rf_write_enable.
- rf_hold asserted while full: wb_ready stays 0 and no entries are lost.

Test Plan:
- Reset, then push (r3, 0x11), (r5, 0x22) on consecutive cycles with rf_hold=0 -> rf_write_enable high for 2 cycles starting 2 cycles after the first accept, with (3,0x11) then (5,0x22); empty returns to 1 afterwards.
- rf_hold=1, push 5 requests with DEPTH=4 -> wb_ready drops after 4 accepts, pending_mask reflects all 4 targets; release rf_hold -> 4 in-order writes, then the 5th request is accepted.
- Push (r2,0xA) then (r2,0xB) with rf_hold=1, fwd_regA=2 -> fwd_hitA=1, fwd_valA=0xB; after the drain completes -> fwd_hitA=0, fwd_valA=0.
- DROP_R0=1, push (r0,0xFFFF) -> handshake completes, no rf_write_enable, pending_mask=0, fwd_hitA=0 for fwd_regA=0.
- Full queue with rf_hold=0 and wb_valid held high -> sustained one accept and one write per cycle once steady; wb_ready never high while count==DEPTH.
- Assert reset with 3 entries queued and a strobe in flight -> next cycle rf_write_enable=0, empty=1, pending_mask=0, and no stale writes after reset deasserts.
